uart_tx: RTL

UART transmitter paired with `uart_rx`. It serialises one byte per request onto a single line at 27 `clk_3125` cycles per bit, about 115200 baud from 3.125 MHz. Each frame has 11 bits: start, 8 data bits MSB first, even parity, stop. The frame format matches what `uart_rx` decodes, so `tx` can be looped directly into `uart_rx.rx` for loopback tests.

---
 rtl/uart_tx.sv | 112 +++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits MSB first, even parity, stop.
// One frame per request; a request held through the stop bit chains frames.
module uart_tx #(
  parameter int CLKS_PER_BIT = 27
) (
  input  logic       clk_3125,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic          par;
  logic          wrap;

  assign wrap = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk_3125) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= 3'd7;
      sh      <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state != IDLE)
        cnt <= wrap ? '0 : cnt + 1'b1;
      unique case (state)
        IDLE: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          if (tx_start) begin
            sh      <= tx_data;
            par     <= ^tx_data;
            cnt     <= '0;
            state   <= START;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        START: begin
          if (wrap) begin
            state <= DATA;
            idx   <= 3'd7;
            tx    <= sh[7];
          end
        end
        DATA: begin
          if (wrap) begin
            if (idx == 3'd0) begin
              state <= PARITY;
              tx    <= par;
            end else begin
              idx <= idx - 3'd1;
              tx  <= sh[idx - 3'd1];
            end
          end
        end
        PARITY: begin
          if (wrap) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          if (wrap) begin
            tx_done <= 1'b1;
            // A request present as the stop bit ends starts the next frame
            // with no idle gap, keeping the frame period at 11 bit times.
            if (tx_start) begin
              sh      <= tx_data;
              par     <= ^tx_data;
              state   <= START;
              tx      <= 1'b0;
              tx_busy <= 1'b1;
            end else begin
              state   <= IDLE;
              tx      <= 1'b1;
              tx_busy <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
